mem_ctrl: RTL and testbench

Single-port memory controller between the pipeline and the byte-wide unified RAM. Arbitrates the instruction-fetch port and the load/store port onto one 8-bit synchronous RAM interface, serialising each 1/2/4-byte access into byte cycles and assembling or splitting 32-bit little-endian words. Sits below the fetch and memory-access stages; it is the only block driving the RAM pins.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl_asm.sv | 39 +++
 rtl/mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_ctrl_pkg : shared types and encodings for the byte-serial memory ctrl  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    if (len == LEN_B)      return 3'd1;
    else if (len == LEN_H) return 3'd2;
    else                   return 3'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_asm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_ctrl_asm : byte-lane insert/zero-fill for reads, byte extract for writes|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_ctrl_asm
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_cap_lane,
  input  logic [7:0]  i_cap_byte,
  input  logic [1:0]  i_len,
  output logic [31:0] o_word_ins,
  output logic [31:0] o_word_zf,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_wr_lane,
  output logic [7:0]  o_wr_byte
);

  always_comb begin
    o_word_ins = i_word;
    o_word_ins[{i_cap_lane, 3'b000} +: 8] = i_cap_byte;
  end

  // zero-fill operates on the freshly inserted word so the final byte lands in the same cycle
  always_comb begin
    case (i_len)
      LEN_B:   o_word_zf = {24'd0, o_word_ins[7:0]};
      LEN_H:   o_word_zf = {16'd0, o_word_ins[15:0]};
      default: o_word_zf = o_word_ins;
    endcase
  end

  always_comb begin
    o_wr_byte = i_wdata[{i_wr_lane, 3'b000} +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_ctrl : arbitrates fetch and load/store onto a byte-wide synchronous RAM |
// | Rev 1.0 ; define MEM_CTRL_STAT_EN to add stat_if / stat_mem counters        |
// +----------------------------------------------------------------------------+
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ok,
  output logic [31:0]       if_data,
  input  logic              flush,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ok,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
`ifdef MEM_CTRL_STAT_EN
  ,
  output logic [31:0]       stat_if,
  output logic [31:0]       stat_mem
`endif
);

  state_t              r_state, w_state_nxt;
  owner_t              r_owner, w_owner_nxt;
  logic                r_we, w_we_nxt;
  logic [1:0]          r_len, w_len_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic [31:0]         r_buf, w_buf_nxt;

  logic                r_if_ok, w_if_ok_nxt;
  logic                r_mem_ok, w_mem_ok_nxt;
  logic [31:0]         r_if_data, w_if_data_nxt;
  logic [31:0]         r_mem_rdata, w_mem_rdata_nxt;
  logic [ADDR_W-1:0]   r_ram_a, w_ram_a_nxt;
  logic                r_ram_wr, w_ram_wr_nxt;
  logic [7:0]          r_ram_din, w_ram_din_nxt;

  logic                w_acc_mem, w_acc_if;
  logic [2:0]          w_nbytes;
  logic [1:0]          w_cap_lane;
  logic [31:0]         w_word_ins, w_word_zf;
  logic [7:0]          w_wr_byte;
  logic                w_unused;

  assign w_unused   = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W], w_word_ins};
  assign w_nbytes   = len_bytes(r_len);
  assign w_cap_lane = r_cnt[1:0] - 2'd1;
  assign w_acc_mem  = (r_state == IDLE) && mem_req;
  assign w_acc_if   = (r_state == IDLE) && !mem_req && if_req && !flush;

  mem_ctrl_asm u_asm (
    .i_word     (r_buf),
    .i_cap_lane (w_cap_lane),
    .i_cap_byte (ram_dout),
    .i_len      (r_len),
    .o_word_ins (w_word_ins),
    .o_word_zf  (w_word_zf),
    .i_wdata    (w_wdata_nxt),
    .i_wr_lane  (w_cnt_nxt[1:0]),
    .o_wr_byte  (w_wr_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (mem_req)                w_state_nxt = mem_we ? WRITE : READ;
        else if (if_req && !flush)  w_state_nxt = READ;
      end
      READ: begin
        if (flush && (r_owner == OWN_IF)) w_state_nxt = IDLE;
        else if (r_cnt == w_nbytes)       w_state_nxt = DONE;
      end
      WRITE: begin
        if (r_cnt == w_nbytes - 3'd1) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // request latch: fields are captured only on acceptance and then frozen
  always_comb begin
    w_owner_nxt = r_owner;
    w_we_nxt    = r_we;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = 3'd0;
    if (w_acc_mem) begin
      w_owner_nxt = OWN_MEM;
      w_we_nxt    = mem_we;
      w_len_nxt   = (mem_len == 2'd2) ? LEN_W : mem_len;
      w_addr_nxt  = mem_addr[ADDR_W-1:0];
      w_wdata_nxt = mem_wdata;
    end else if (w_acc_if) begin
      w_owner_nxt = OWN_IF;
      w_we_nxt    = 1'b0;
      w_len_nxt   = LEN_W;
      w_addr_nxt  = if_addr[ADDR_W-1:0];
    end
    if ((r_state == READ) || (r_state == WRITE)) w_cnt_nxt = r_cnt + 3'd1;
  end

  // outputs are computed for the state being entered so every pin comes straight from a flop
  always_comb begin
    w_buf_nxt       = r_buf;
    w_if_ok_nxt     = 1'b0;
    w_mem_ok_nxt    = 1'b0;
    w_if_data_nxt   = r_if_data;
    w_mem_rdata_nxt = r_mem_rdata;
    w_ram_a_nxt     = '0;
    w_ram_wr_nxt    = 1'b0;
    w_ram_din_nxt   = 8'd0;
    if (w_acc_mem || w_acc_if)                w_buf_nxt = 32'd0;
    else if ((r_state == READ) && (r_cnt != 3'd0)) w_buf_nxt = w_word_ins;
    if ((w_state_nxt == READ) && (w_cnt_nxt < len_bytes(w_len_nxt)))
      w_ram_a_nxt = w_addr_nxt + ADDR_W'(w_cnt_nxt);
    if (w_state_nxt == WRITE) begin
      w_ram_a_nxt   = w_addr_nxt + ADDR_W'(w_cnt_nxt);
      w_ram_wr_nxt  = 1'b1;
      w_ram_din_nxt = w_wr_byte;
    end
    if (w_state_nxt == DONE) begin
      if (r_owner == OWN_IF) begin
        w_if_ok_nxt   = 1'b1;
        w_if_data_nxt = w_word_zf;
      end else begin
        w_mem_ok_nxt = 1'b1;
        if (!r_we) w_mem_rdata_nxt = w_word_zf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_len       <= LEN_B;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_cnt       <= 3'd0;
      r_buf       <= 32'd0;
      r_if_ok     <= 1'b0;
      r_mem_ok    <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_ram_a     <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_din   <= 8'd0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_we        <= w_we_nxt;
      r_len       <= w_len_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf       <= w_buf_nxt;
      r_if_ok     <= w_if_ok_nxt;
      r_mem_ok    <= w_mem_ok_nxt;
      r_if_data   <= w_if_data_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_ram_a     <= w_ram_a_nxt;
      r_ram_wr    <= w_ram_wr_nxt;
      r_ram_din   <= w_ram_din_nxt;
    end
  end

  assign if_ok     = r_if_ok;
  assign if_data   = r_if_data;
  assign mem_ok    = r_mem_ok;
  assign mem_rdata = r_mem_rdata;
  assign ram_a     = r_ram_a;
  assign ram_wr    = r_ram_wr;
  assign ram_din   = r_ram_din;

`ifdef MEM_CTRL_STAT_EN
  logic [31:0] r_stat_if, r_stat_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_if  <= 32'd0;
      r_stat_mem <= 32'd0;
    end else begin
      if (w_if_ok_nxt)  r_stat_if  <= r_stat_if + 32'd1;
      if (w_mem_ok_nxt) r_stat_mem <= r_stat_mem + 32'd1;
    end
  end

  assign stat_if  = r_stat_if;
  assign stat_mem = r_stat_mem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// tb_mem_ctrl : randomized + directed bench with a byte-array RAM and a shadow-memory reference model
module tb_mem_ctrl;

  localparam int AW    = 17;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0]   if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [1:0]    mem_len = '0;
  logic          if_ok, mem_ok, ram_wr;
  logic [31:0]   if_data, mem_rdata;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout = '0;
`ifdef MEM_CTRL_STAT_EN
  logic [31:0]   stat_if, stat_mem;
`endif

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ok(mem_ok), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef MEM_CTRL_STAT_EN
    , .stat_if(stat_if), .stat_mem(stat_mem)
`endif
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 5));
  endfunction

  // environment RAM; only this process writes it
  logic [7:0]    ram [0:MEMSZ-1];
  logic [7:0]    shadow [0:MEMSZ-1];
  bit            filled = 1'b0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [7:0]    poke_d = '0;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < MEMSZ; i++) ram[i] <= init_byte(i);
      filled <= 1'b1;
    end else if (ram_wr) ram[ram_a] <= ram_din;
    else if (poke_en)    ram[poke_a] <= poke_d;
    ram_dout <= ram[ram_a];
  end

  int          vectors = 0, errors = 0;
  logic [31:0] last_if = '0, last_mem = '0;
  bit          mem_known = 1'b1;
  logic [31:0] exp_sif = '0, exp_smem = '0;

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic check_stats();
`ifdef MEM_CTRL_STAT_EN
    vectors++;
    if (stat_if !== exp_sif) begin errors++; $display("FAIL stat_if: got %0d want %0d", stat_if, exp_sif); end
    vectors++;
    if (stat_mem !== exp_smem) begin errors++; $display("FAIL stat_mem: got %0d want %0d", stat_mem, exp_smem); end
`endif
  endtask

  // one complete transaction; expectations come from the shadow memory and the latency rules
  task automatic do_access(input bit is_if, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata, input int flush_at);
    int nb, lat;
    logic [31:0] exp;
    logic [AW-1:0] a;
    nb  = is_if ? 4 : ((len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4));
    lat = (!is_if && we) ? nb + 1 : nb + 2;
    exp = '0;
    for (int i = 0; i < nb; i++) begin
      a = addr[AW-1:0] + AW'(i);
      exp[8*i +: 8] = shadow[a];
    end
    @(negedge clk);
    if (is_if) begin if_req = 1'b1; if_addr = addr; end
    else begin mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata; end
    @(posedge clk);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      flush = (n == flush_at);
      a = addr[AW-1:0] + AW'(n - 1);
      vectors++;
      if (if_ok !== (is_if && n == lat)) begin errors++; $display("FAIL if_ok cyc %0d: got %b want %b", n, if_ok, is_if && n == lat); end
      vectors++;
      if (mem_ok !== (!is_if && n == lat)) begin errors++; $display("FAIL mem_ok cyc %0d: got %b want %b", n, mem_ok, !is_if && n == lat); end
      if (n <= nb) begin
        vectors++;
        if (ram_a !== a) begin errors++; $display("FAIL ram_a cyc %0d: got %h want %h", n, ram_a, a); end
        vectors++;
        if (ram_wr !== (!is_if && we)) begin errors++; $display("FAIL ram_wr cyc %0d: got %b want %b", n, ram_wr, !is_if && we); end
        if (!is_if && we) begin
          vectors++;
          if (ram_din !== wdata[8*(n-1) +: 8]) begin errors++; $display("FAIL ram_din cyc %0d: got %h want %h", n, ram_din, wdata[8*(n-1) +: 8]); end
        end
      end
      if (n == lat) begin
        flush = 1'b0;
        if (is_if) begin
          vectors++;
          if (if_data !== exp) begin errors++; $display("FAIL if_data @%h: got %h want %h", addr, if_data, exp); end
          if (mem_known) begin
            vectors++;
            if (mem_rdata !== last_mem) begin errors++; $display("FAIL mem_rdata hold: got %h want %h", mem_rdata, last_mem); end
          end
          last_if = exp; exp_sif++; if_req = 1'b0;
        end else begin
          if (!we) begin
            vectors++;
            if (mem_rdata !== exp) begin errors++; $display("FAIL mem_rdata @%h len %0d: got %h want %h", addr, len, mem_rdata, exp); end
            last_mem = exp; mem_known = 1'b1;
          end else begin
            for (int i = 0; i < nb; i++) begin
              a = addr[AW-1:0] + AW'(i);
              shadow[a] = wdata[8*i +: 8];
            end
            mem_known = 1'b0;
          end
          vectors++;
          if (if_data !== last_if) begin errors++; $display("FAIL if_data hold: got %h want %h", if_data, last_if); end
          exp_smem++; mem_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({if_ok, mem_ok, ram_wr, ram_din, ram_a, if_data, mem_rdata} !== '0) begin
      errors++; $display("FAIL reset outputs: got %h want 0", {if_ok, mem_ok, ram_wr, ram_din, ram_a, if_data, mem_rdata});
    end
    check_stats();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({if_ok, mem_ok, ram_wr, ram_din, ram_a} !== '0) begin
      errors++; $display("FAIL idle outputs: got %h want 0", {if_ok, mem_ok, ram_wr, ram_din, ram_a});
    end
  endtask

  task automatic test_fetch();
    poke(17'h0, 8'h13); poke(17'h1, 8'h05); poke(17'h2, 8'h00); poke(17'h3, 8'h00);
    do_access(1'b1, 1'b0, 2'd3, 32'h0000_0000, '0, 0);
    do_access(1'b1, 1'b0, 2'd3, 32'h0000_0A31, '0, 0);
  endtask

  task automatic test_priority();
    logic [31:0] exp_if;
    poke(17'h100, 8'hFF);
    exp_if = {shadow[17'h843], shadow[17'h842], shadow[17'h841], shadow[17'h840]};
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0000_0100;
    if_req = 1'b1; if_addr = 32'h0000_0840;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      vectors++;
      if (mem_ok !== (n == 3)) begin errors++; $display("FAIL prio mem_ok cyc %0d: got %b want %b", n, mem_ok, n == 3); end
      vectors++;
      if (if_ok !== (n == 10)) begin errors++; $display("FAIL prio if_ok cyc %0d: got %b want %b", n, if_ok, n == 10); end
      if (n == 3) begin
        vectors++;
        if (mem_rdata !== 32'h0000_00FF) begin errors++; $display("FAIL prio mem_rdata: got %h want 000000ff", mem_rdata); end
        last_mem = 32'h0000_00FF; mem_known = 1'b1; exp_smem++; mem_req = 1'b0;
      end
      if (n == 10) begin
        vectors++;
        if (if_data !== exp_if) begin errors++; $display("FAIL prio if_data: got %h want %h", if_data, exp_if); end
        last_if = exp_if; exp_sif++; if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 2'd3, 32'h0000_0200, 32'hDEADBEEF, 0);
    do_access(1'b0, 1'b0, 2'd3, 32'h0000_0200, '0, 0);
    do_access(1'b0, 1'b1, 2'd0, 32'h0000_0201, 32'h1234_5677, 0);
    do_access(1'b0, 1'b0, 2'd1, 32'h0000_0201, '0, 0);
    do_access(1'b0, 1'b0, 2'd2, 32'h0000_0200, '0, 0);
  endtask

  task automatic test_flush();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_1234;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 3) begin flush = 1'b1; if_req = 1'b0; end
      if (n == 4) flush = 1'b0;
      vectors++;
      if (if_ok !== 1'b0) begin errors++; $display("FAIL flush if_ok cyc %0d: got %b want 0", n, if_ok); end
      if (n >= 4) begin
        vectors++;
        if (ram_a !== '0) begin errors++; $display("FAIL flush ram_a cyc %0d: got %h want 0", n, ram_a); end
      end
    end
    vectors++;
    if (if_data !== last_if) begin errors++; $display("FAIL flush if_data: got %h want %h", if_data, last_if); end
  endtask

  task automatic test_wrap();
    do_access(1'b0, 1'b0, 2'd3, 32'h0001_FFFE, '0, 0);
    do_access(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, '0, 0);
    do_access(1'b0, 1'b1, 2'd3, 32'h0003_FFFF, 32'hA5C3_0F96, 0);
    do_access(1'b0, 1'b0, 2'd3, 32'h0001_FFFF, '0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit is_if, we;
      int fa;
      is_if = 1'($urandom);
      we    = !is_if && 1'($urandom);
      fa    = (!is_if && ($urandom_range(2) == 0)) ? 1 + int'($urandom_range(1)) : 0;
      do_access(is_if, we, 2'($urandom), $urandom, $urandom, fa);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [AW-1:0] a;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h0000_0300; mem_wdata = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0;
    #1;
    vectors++;
    if ({if_ok, mem_ok, ram_wr, ram_din, ram_a, if_data, mem_rdata} !== '0) begin
      errors++; $display("FAIL midwrite reset outputs: got %h want 0", {if_ok, mem_ok, ram_wr, ram_din, ram_a, if_data, mem_rdata});
    end
    exp_sif = '0; exp_smem = '0; last_if = '0; last_mem = '0; mem_known = 1'b1;
    check_stats();
    @(negedge clk);
    rst = 1'b1;
    // an interrupted store leaves undefined bytes; resynchronise the model to the RAM
    for (int i = 0; i < 4; i++) begin
      a = 17'h300 + AW'(i);
      shadow[a] = ram[a];
    end
    do_access(1'b1, 1'b0, 2'd3, 32'h0000_0A31, '0, 0);
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) shadow[i] = init_byte(i);
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_wrap();
    test_random();
    check_stats();
    test_reset_mid_write();
    check_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
